// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial-in, parallel-out shift register:
// default geometry, default reset value and shift-direction encoding.
package shift_reg_pkg;

  // Default register length.
  localparam int DEFAULT_WIDTH = 8;

  // Widest register supported; RESET_VALUE is carried in a container this wide.
  localparam int MAX_WIDTH = 64;

  // Default reset value (all zeros in every bit position).
  localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

  // Shift-direction encoding used by MSB_FIRST_OUT.
  // SHIFT_TO_MSB: din enters bit 0, the oldest bit leaves from bit WIDTH-1.
  // SHIFT_TO_LSB: din enters bit WIDTH-1, the oldest bit leaves from bit 0.
  localparam bit SHIFT_TO_MSB = 1'b1;
  localparam bit SHIFT_TO_LSB = 1'b0;

endpackage : shift_reg_pkg

// File: rtl/shift_reg.sv
// Serial-in, parallel-out shift register. One bit of din is captured on
// every rising clk edge outside reset; the whole register is visible on a.
// There is no enable and no handshake.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int                   WIDTH         = DEFAULT_WIDTH,
  // Held in a MAX_WIDTH container so an oversize value can be rejected at
  // elaboration instead of being silently truncated.
  parameter logic [MAX_WIDTH-1:0] RESET_VALUE   = DEFAULT_RESET_VALUE,
  parameter bit                   MSB_FIRST_OUT = SHIFT_TO_MSB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] a
);

  logic [WIDTH-1:0] next_a;

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("shift_reg: WIDTH must be in 2..%0d", MAX_WIDTH);
  end

  if ((RESET_VALUE >> WIDTH) != '0) begin : g_bad_reset_value
    $error("shift_reg: RESET_VALUE does not fit in WIDTH bits");
  end

  // Direction is fixed at elaboration, so only one shift network is built.
  if (MSB_FIRST_OUT == SHIFT_TO_MSB) begin : g_shift_msb
    assign next_a = {a[WIDTH-2:0], din};
  end else begin : g_shift_lsb
    assign next_a = {din, a[WIDTH-1:1]};
  end

  // Register update: reset wins over shifting; din at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      a <= RESET_VALUE[WIDTH-1:0];
    end else begin
      a <= next_a;
    end
  end

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// Testbench for shift_reg: default 8-bit MSB-ward instance plus a 4-bit
// LSB-ward instance with a non-zero reset value.
module tb_shift_reg;

  logic       clk;
  logic       rst8, din8;
  logic [7:0] a8;
  logic       rst4, din4;
  logic [3:0] a4;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit         rst;
    bit         din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp8_q[$];
  logic [3:0] exp4_q[$];

  shift_reg dut8 (
    .clk   (clk),
    .reset (rst8),
    .din   (din8),
    .a     (a8)
  );

  shift_reg #(
    .WIDTH         (4),
    .RESET_VALUE   (64'hA),
    .MSB_FIRST_OUT (1'b0)
  ) dut4 (
    .clk   (clk),
    .reset (rst4),
    .din   (din4),
    .a     (a4)
  );

  initial begin
    clk = 1'b0;
    forever #15 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit r, input bit d, input logic [7:0] e);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  // Drive both DUTs away from the active edge, queue expectations,
  // then compare just after the edge.
  task automatic step(input bit r8, input bit d8, input logic [7:0] e8,
                      input bit r4, input bit d4, input logic [3:0] e4,
                      input string name);
    logic [7:0] x8;
    logic [3:0] x4;
    @(negedge clk);
    rst8 = r8; din8 = d8;
    rst4 = r4; din4 = d4;
    exp8_q.push_back(e8);
    exp4_q.push_back(e4);
    @(posedge clk);
    #1;
    x8 = exp8_q.pop_front();
    x4 = exp4_q.pop_front();
    check({name, "_a8"}, 64'(a8), 64'(x8));
    check({name, "_a4"}, 64'(a4), 64'(x4));
  endtask

  initial begin
    logic [7:0] m8;
    logic [3:0] m4;
    bit r, d, r4b, d4b;

    rst8 = 1'b0; din8 = 1'b0;
    rst4 = 1'b0; din4 = 1'b0;

    // Vector table for the default instance: {reset, din, expected a}.
    add(1, 1, 8'h00);                                    // reset with din=1
    add(0, 1, 8'h01); add(0, 1, 8'h03); add(0, 1, 8'h07); add(0, 1, 8'h0F);
    add(0, 1, 8'h1F); add(0, 1, 8'h3F); add(0, 1, 8'h7F); add(0, 1, 8'hFF);
    add(0, 0, 8'hFE); add(0, 0, 8'hFC); add(0, 0, 8'hF8); add(0, 0, 8'hF0);
    add(0, 0, 8'hE0); add(0, 0, 8'hC0); add(0, 0, 8'h80); add(0, 0, 8'h00);
    add(0, 0, 8'h00);                                    // 9th drain edge
    add(0, 1, 8'h01); add(0, 0, 8'h02); add(0, 1, 8'h05); add(0, 1, 8'h0B);
    add(0, 0, 8'h16); add(0, 0, 8'h2C); add(0, 1, 8'h59); add(0, 0, 8'hB2);
    add(0, 1, 8'h65);                                    // bit 7 lost

    // Apply the table; the 4-bit instance is held in reset meanwhile.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].din, vecs[i].exp, 1'b1, 1'b0, 4'hA,
           $sformatf("vec%0d", i));
    end

    // Mid-stream reset: build 0x5A, reset with din=1, then restart.
    step(1, 0, 8'h00, 1, 0, 4'hA, "pre5a_rst");
    step(0, 0, 8'h00, 1, 0, 4'hA, "b5a_0");
    step(0, 1, 8'h01, 1, 0, 4'hA, "b5a_1");
    step(0, 0, 8'h02, 1, 0, 4'hA, "b5a_2");
    step(0, 1, 8'h05, 1, 0, 4'hA, "b5a_3");
    step(0, 1, 8'h0B, 1, 0, 4'hA, "b5a_4");
    step(0, 0, 8'h16, 1, 0, 4'hA, "b5a_5");
    step(0, 1, 8'h2D, 1, 0, 4'hA, "b5a_6");
    step(0, 0, 8'h5A, 1, 0, 4'hA, "b5a_7");
    step(1, 1, 8'h00, 1, 0, 4'hA, "mid_rst");
    step(0, 1, 8'h01, 1, 0, 4'hA, "post_rst");

    // No combinational path: toggling din between edges must not move a.
    @(negedge clk);
    din8 = 1'b0;
    #3;
    check("no_comb_din", 64'(a8), 64'h01);
    rst8 = 1'b1;
    #3;
    check("no_comb_rst", 64'(a8), 64'h01);

    // 4-bit LSB-ward variant with reset value 0xA.
    step(1, 0, 8'h00, 1, 1, 4'hA, "w4_rst");
    step(1, 0, 8'h00, 0, 1, 4'hD, "w4_din1");
    step(1, 0, 8'h00, 0, 0, 4'h6, "w4_din0");

    // Random din/reset against a reference model on both instances.
    m8 = 8'h00;
    m4 = 4'h6;
    for (int i = 0; i < 1000; i++) begin
      r   = ($urandom_range(0, 9) == 0);
      d   = $urandom_range(0, 1);
      r4b = ($urandom_range(0, 9) == 0);
      d4b = $urandom_range(0, 1);
      m8 = r ? 8'h00 : {m8[6:0], d};
      m4 = r4b ? 4'hA : {d4b, m4[3:1]};
      step(r, d, m8, r4b, d4b, m4, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_shift_reg
